seq_alu_hs: RTL and testbench
=============================

Name: seq_alu_hs

Overview:
Parametrised, registered successor to the team's 4-bit combinational add/sub/and/or ALU. Generalised to WIDTH bits and an 8-entry op set, with a valid/ready handshake on both sides, registered status flags and an iterative shift-add multiplier. Sits between an operand-issue stage and a result consumer in the datapath. Results are always registered, never combinational from the inputs.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, at least 4.
SHW, $clog2(WIDTH), shift-amount width (derived; not to be overridden).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  operands and op present
in_ready  output  1  block can accept an op this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op_code  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
carry_out  output  1  carry / no-borrow / shifted-out bit / product overflow
zero  output  1  result == 0
negative  output  1  result[WIDTH-1]
overflow  output  1  signed overflow (ADD/SUB only, else 0)
err  output  1  illegal op (MUL with the multiplier compiled out)

Behaviour:
- Reset: async, active-high, one clock, active-high polarity fixed. State goes to IDLE. result, carry_out, zero, negative, overflow, err and out_valid all go to 0. in_ready is 1 after reset is released.
- States: IDLE, BUSY (MUL iteration), DONE (result held).
- in_ready = (state==IDLE) || (state==DONE && out_ready). A transfer occurs when in_valid && in_ready.
- Single-cycle ops: on transfer at edge k, result/flags are registered at edge k and out_valid=1 from edge k. State goes to DONE. With out_ready held at 1, throughput is one op per cycle.
- MUL: on transfer, capture operands and go to BUSY for exactly WIDTH cycles (one shift-add step per cycle). Then result = low WIDTH bits of the unsigned product, carry_out = |high WIDTH bits, and go to DONE. out_valid rises WIDTH cycles after the accepting edge.
- DONE: outputs are held stable while out_ready=0. When out_ready=1 and there is no new transfer, go to IDLE and clear out_valid. When out_ready=1 and there is a simultaneous transfer, load the new op (DONE or BUSY); out_valid stays 1 only if the new op is single-cycle.
- in_ready=0 in BUSY. Inputs are ignored there.
- ADD: {carry_out,result} = a+b.
- SUB: result = a + ~b + 1. carry_out=1 means no borrow (borrow = ~carry_out).
- overflow = signed overflow of the ADD/SUB.
- AND/OR/XOR: bitwise; carry_out=0.
- SHL/SHR: logical shift of a by b[SHW-1:0]. carry_out = last bit shifted out. A shift amount of 0 gives result=a, carry_out=0.
- zero and negative are computed from the final result for every op. err=0 for every legal op.
- Reset asserted mid-MUL aborts the op immediately. No partial result is ever presented.

Optional Feature:
ALU_MUL_EN
- Defined: MUL is implemented as above.
- Undefined: no multiplier logic and no BUSY state. op 111 completes in a single cycle with result=0, carry_out=0, zero=1, err=1.

Test Plan:
- WIDTH=8: reset asserted with in_valid=1 -> all outputs 0, out_valid=0. After release, in_ready=1.
- ADD a=7 b=3 -> result=10, carry_out=0. ADD a=255 b=1 -> result=0, carry_out=1, zero=1.
- SUB a=7 b=3 -> result=4, carry_out=1. SUB a=3 b=7 -> result=252, carry_out=0, negative=1. SUB a=128 b=1 -> overflow=1.
- AND/OR/XOR a=8'hF0 b=8'h3C -> 8'h30 / 8'hFC / 8'hCC. SHL a=8'h81 b=1 -> 8'h02, carry_out=1. SHR a=8'h81 b=0 -> 8'h81, carry_out=0.
- ALU_MUL_EN defined: MUL 15*17 -> out_valid exactly 8 cycles after accept, result=255, carry_out=0. MUL 16*16 -> result=0, carry_out=1. Reset pulsed in cycle 3 of BUSY -> out_valid never rises. Without the macro: MUL -> err=1, result=0 next cycle.
- Back-pressure: out_ready=0 for 5 cycles -> result stable, in_ready=0. Then 4 back-to-back ADDs with out_ready=1 -> one result per cycle, in order.

Source files
------------

// File: rtl/seq_alu_hs.sv
// Registered WIDTH-bit ALU with valid/ready handshake on both sides and status flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for op 111.
module seq_alu_hs #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             err
);

  localparam int unsigned XW  = WIDTH + 1;
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  localparam int unsigned PW = 2 * WIDTH;
  logic [PW-1:0]    acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
  logic             ovf_q, ovf_d, err_q, err_d, valid_q, valid_d;

  logic [WIDTH-1:0] b_sel, alu_res;
  logic [XW-1:0]    add_ext, shl_ext, shr_ext;
  logic [SHW-1:0]   sh;
  logic             alu_c, alu_v, alu_e, xfer, load;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign xfer     = in_valid && in_ready;

  // Single-cycle datapath; shifts run one bit wider so the last bit out lands in the extra slot
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    sh      = b[SHW-1:0];
    b_sel   = (op_code == OP_SUB) ? ~b : b;
    add_ext = {1'b0, a} + {1'b0, b_sel} + XW'(op_code == OP_SUB);
    shl_ext = {1'b0, a} << sh;
    shr_ext = {a, 1'b0} >> sh;
    case (op_code)
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (add_ext[MSB] != a[MSB]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      OP_MUL: begin
`ifndef ALU_MUL_EN
        alu_e = 1'b1;
`endif
      end
      default: alu_res = '0;
    endcase
  end

  // Handshake FSM, flag capture and multiplier sequencing
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    valid_d  = valid_q;
    load     = 1'b0;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
      IDLE: load = xfer;
`ifdef ALU_MUL_EN
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d  = DONE;
          valid_d  = 1'b1;
          result_d = acc_step[WIDTH-1:0];
          carry_d  = |acc_step[PW-1:WIDTH];
          zero_d   = (acc_step[WIDTH-1:0] == '0);
          neg_d    = acc_step[MSB];
          ovf_d    = 1'b0;
          err_d    = 1'b0;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          if (xfer) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    if (load) begin
`ifdef ALU_MUL_EN
      if (op_code == OP_MUL) begin
        state_d  = BUSY;
        valid_d  = 1'b0;
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        cnt_d    = '0;
      end else
`endif
      begin
        state_d  = DONE;
        valid_d  = 1'b1;
        result_d = alu_res;
        carry_d  = alu_c;
        zero_d   = (alu_res == '0);
        neg_d    = alu_res[MSB];
        ovf_d    = alu_v;
        err_d    = alu_e;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign overflow  = ovf_q;
  assign err       = err_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_seq_alu_hs.sv
// Bench for seq_alu_hs: arithmetic reference model with an in-order scoreboard,
// plus directed vectors with literal expectations. Honours ALU_MUL_EN like the RTL.
module tb_seq_alu_hs;

  localparam int unsigned W = 8;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, ANDO = 3'd2, ORO = 3'd3;
  localparam logic [2:0] XORO = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [2:0]   op_code;
  logic         carry_out, zero, negative, overflow, err;

  typedef struct packed {
    logic [W-1:0] res;
    logic c, z, n, v, e;
  } exp_t;

  int   checks = 0;
  int   passes = 0;
  exp_t q[$];

  seq_alu_hs #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_code(op_code), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .zero(zero), .negative(negative),
    .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic, wrap modulo 2^W, signed range check for overflow
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] av,
                                 input logic [W-1:0] bv);
    longint ua, ub, sa, sb, r, full, sh;
    exp_t e;
    e    = '0;
    ua   = longint'(av);
    ub   = longint'(bv);
    full = longint'(1) << W;
    sa   = (ua >= full / 2) ? ua - full : ua;
    sb   = (ub >= full / 2) ? ub - full : ub;
    sh   = ub % W;
    r    = 0;
    case (op)
      ADD: begin
        r   = ua + ub;
        e.c = (r >= full);
        e.v = ((sa + sb) >= full / 2) || ((sa + sb) < -(full / 2));
      end
      SUB: begin
        r   = ua - ub;
        e.c = (ua >= ub);
        e.v = ((sa - sb) >= full / 2) || ((sa - sb) < -(full / 2));
      end
      ANDO: r = ua & ub;
      ORO:  r = ua | ub;
      XORO: r = ua ^ ub;
      SHL: begin
        r   = ua << sh;
        e.c = (sh != 0) && (((ua >> (W - sh)) & 1) != 0);
      end
      SHR: begin
        r   = ua >> sh;
        e.c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0);
      end
      default: begin
`ifdef ALU_MUL_EN
        r   = ua * ub;
        e.c = (r >= full);
`else
        r   = 0;
        e.e = 1'b1;
`endif
      end
    endcase
    r     = ((r % full) + full) % full;
    e.res = W'(r);
    e.z   = (r == 0);
    e.n   = (r >= full / 2);
    return e;
  endfunction

  task automatic chk(input string name, input longint got, input longint expv);
    checks++;
    if (got == expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, expv);
  endtask

  // Scoreboard: compare every presented result, retire on consumer accept, enqueue on input accept
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL monitor_unexpected: got result %0h with nothing expected", result);
        end else begin
          chk("monitor", {result, carry_out, zero, negative, overflow, err}, longint'(q[0]));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(op_code, a, b));
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    op_code  = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    $display("FAIL send_timeout: in_ready stayed 0 for op %0d", op);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic seen;
    rst = 1'b1; in_valid = 1'b1; op_code = ADD; a = 8'd5; b = 8'd6; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {result, carry_out, zero, negative, overflow, err, out_valid}, 0);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    send(ADD, 8'd7, 8'd3);      chk("add_7_3", {result, carry_out}, {8'd10, 1'b0});
    send(ADD, 8'd255, 8'd1);    chk("add_255_1", {result, carry_out, zero}, {8'd0, 1'b1, 1'b1});
    send(SUB, 8'd7, 8'd3);      chk("sub_7_3", {result, carry_out}, {8'd4, 1'b1});
    send(SUB, 8'd3, 8'd7);      chk("sub_3_7", {result, carry_out, negative}, {8'd252, 1'b0, 1'b1});
    send(SUB, 8'd128, 8'd1);    chk("sub_128_1_ovf", {result, overflow}, {8'd127, 1'b1});
    send(ANDO, 8'hF0, 8'h3C);   chk("and", result, 8'h30);
    send(ORO, 8'hF0, 8'h3C);    chk("or", result, 8'hFC);
    send(XORO, 8'hF0, 8'h3C);   chk("xor", result, 8'hCC);
    send(SHL, 8'h81, 8'd1);     chk("shl_81_1", {result, carry_out}, {8'h02, 1'b1});
    send(SHR, 8'h81, 8'd0);     chk("shr_81_0", {result, carry_out}, {8'h81, 1'b0});
    send(SHR, 8'h81, 8'd3);     chk("shr_81_3", {result, carry_out}, {8'h10, 1'b0});
    send(SHL, 8'h2C, 8'd6);     chk("shl_2c_6", {result, carry_out}, {8'h00, 1'b1});

`ifdef ALU_MUL_EN
    send(MUL, 8'd15, 8'd17);
    lat = 0;
    while (!out_valid && lat < 3 * W) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("mul_latency", lat, W);
    chk("mul_15_17", {result, carry_out}, {8'd255, 1'b0});
    @(posedge clk);
    #1;
    send(MUL, 8'd16, 8'd16);
    repeat (W) @(posedge clk);
    #1;
    chk("mul_16_16", {out_valid, result, carry_out, zero}, {1'b1, 8'd0, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    send(MUL, 8'd3, 8'd5);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mul_abort_no_valid", seen, 0);
    chk("mul_abort_in_ready", in_ready, 1);
`else
    send(MUL, 8'd15, 8'd17);
    chk("mul_disabled", {out_valid, result, carry_out, zero, err}, {1'b1, 8'd0, 1'b0, 1'b1, 1'b1});
    @(posedge clk);
    #1;
`endif

    out_ready = 1'b0;
    send(ADD, 8'd20, 8'd22);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("backpressure_hold", {out_valid, in_ready, result}, {1'b1, 1'b0, 8'd42});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op_code  = ADD;
      a        = W'(i * 16 + 1);
      b        = W'(i + 2);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("b2b_add", {out_valid, result}, {1'b1, W'((i * 16 + 1) + (i + 2))});
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_out_valid", out_valid, 0);
    chk("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
